// File: rtl/sms_pkg.sv
// Shared definitions for the SMS controller input path: pad width,
// button bit positions and the NMI sequencer states.
package sms_pkg;

    localparam int PAD_W = 6;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_B1    = 4;
    localparam int BTN_B2    = 5;

    typedef enum logic [1:0] {
        NMI_IDLE,
        NMI_PULSE,
        NMI_WAIT_REL
    } nmi_state_t;

endpackage

// File: rtl/joypad_conditioner_if.sv
// Pin bundle between the raw controller/PAUSE lines and the Z80-facing
// conditioned outputs. The conditioner is the slave side.
interface joypad_conditioner_if;
    import sms_pkg::*;

    logic [PAD_W-1:0] ja_raw;
    logic [PAD_W-1:0] jb_raw;
    logic             pause_raw;
    logic [PAD_W-1:0] controller_1;
    logic [PAD_W-1:0] controller_2;
    logic             nmi_l;
    logic             pause_held;

    modport master (
        output ja_raw, jb_raw, pause_raw,
        input  controller_1, controller_2, nmi_l, pause_held
    );

    modport slave (
        input  ja_raw, jb_raw, pause_raw,
        output controller_1, controller_2, nmi_l, pause_held
    );

endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a persistence counter for one
// active-low button line; idles in the released (1) state.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Any sample that agrees with the accepted level discards progress,
    // so only an uninterrupted run of the new level is ever accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/joypad_conditioner.sv
// Conditions both controller ports and PAUSE, and turns each debounced
// PAUSE press into one fixed-width active-low NMI pulse for the Z80.
module joypad_conditioner
    import sms_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int NMI_PULSE_CYCLES = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    joypad_conditioner_if.slave  pad
);

    localparam int NUM_SIG = 2 * PAD_W + 1;
    localparam int PCNT_W  = (NMI_PULSE_CYCLES > 1) ? $clog2(NMI_PULSE_CYCLES) : 1;

    logic [NUM_SIG-1:0] raw_bus;
    logic [NUM_SIG-1:0] stable_bus;
    logic               stable_pause;

    assign raw_bus = {pad.pause_raw, pad.jb_raw, pad.ja_raw};

    for (genvar i = 0; i < NUM_SIG; i++) begin : g_debounce
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .raw    (raw_bus[i]),
            .stable (stable_bus[i])
        );
    end

    assign pad.controller_1 = stable_bus[PAD_W-1:0];
    assign pad.controller_2 = stable_bus[2*PAD_W-1:PAD_W];
    assign stable_pause     = stable_bus[2*PAD_W];
    assign pad.pause_held   = ~stable_pause;

    nmi_state_t        state;
    nmi_state_t        next_state;
    logic [PCNT_W-1:0] pcnt;
    logic              pause_d;
    logic              nmi_q;
    logic              nmi_next;

    // nmi_l comes straight from nmi_q so the Z80 never sees a decode glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= NMI_IDLE;
            pcnt    <= '0;
            pause_d <= 1'b1;
            nmi_q   <= 1'b1;
        end else begin
            state   <= next_state;
            pause_d <= stable_pause;
            nmi_q   <= nmi_next;
            pcnt    <= (state == NMI_PULSE) ? pcnt + PCNT_W'(1) : '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            NMI_IDLE: begin
                if (pause_d && !stable_pause) next_state = NMI_PULSE;
            end
            NMI_PULSE: begin
                if (pcnt == PCNT_W'(NMI_PULSE_CYCLES - 1)) next_state = NMI_WAIT_REL;
            end
            NMI_WAIT_REL: begin
                if (stable_pause) next_state = NMI_IDLE;
            end
            default: next_state = NMI_IDLE;
        endcase
    end

    always_comb begin
        nmi_next = (next_state != NMI_PULSE);
    end

    assign pad.nmi_l = nmi_q;

endmodule

// File: tb/tb_joypad_conditioner.sv
// Directed bench for joypad_conditioner: expected outputs are queued with
// their due cycle when stimulus is applied and checked when that cycle arrives.
module tb_joypad_conditioner;
    import sms_pkg::*;

    localparam int DEB  = 4;
    localparam int NMIW = 8;

    logic clock = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         at;
        string      tag;
        logic [5:0] c1;
        logic [5:0] c2;
        logic       nmi;
        logic       held;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    joypad_conditioner_if pad_if ();

    joypad_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .NMI_PULSE_CYCLES (NMIW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pad   (pad_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input logic p);
        pad_if.ja_raw    = a;
        pad_if.jb_raw    = b;
        pad_if.pause_raw = p;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] c1, input logic [5:0] c2,
                               input logic nmi, input logic held);
        checks++;
        assert (pad_if.controller_1 === c1) else begin
            errors++;
            $error("[TB] FAIL %s controller_1: got %h expected %h", tag, pad_if.controller_1, c1);
        end
        checks++;
        assert (pad_if.controller_2 === c2) else begin
            errors++;
            $error("[TB] FAIL %s controller_2: got %h expected %h", tag, pad_if.controller_2, c2);
        end
        checks++;
        assert (pad_if.nmi_l === nmi) else begin
            errors++;
            $error("[TB] FAIL %s nmi_l: got %b expected %b", tag, pad_if.nmi_l, nmi);
        end
        checks++;
        assert (pad_if.pause_held === held) else begin
            errors++;
            $error("[TB] FAIL %s pause_held: got %b expected %b", tag, pad_if.pause_held, held);
        end
    endtask

    task automatic push_exp(input int at, input string tag, input logic [5:0] c1,
                            input logic [5:0] c2, input logic nmi, input logic held);
        exp_t e;
        int   i;
        e.at = at; e.tag = tag; e.c1 = c1; e.c2 = c2; e.nmi = nmi; e.held = held;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    // PAUSE pressed before edge t+1: held from edge t+DEB+2, NMI low for NMIW cycles after that.
    task automatic push_press(input int t, input int n, input string tag);
        for (int k = 1; k <= n; k++)
            push_exp(t + k, tag, 6'h3F, 6'h3F,
                     !((k >= DEB + 3) && (k <= DEB + 2 + NMIW)), (k >= DEB + 2));
    endtask

    task automatic push_release(input int t, input int n, input string tag);
        for (int k = 1; k <= n; k++)
            push_exp(t + k, tag, 6'h3F, 6'h3F, 1'b1, (k < DEB + 2));
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            checkOutput(cur.tag, cur.c1, cur.c2, cur.nmi, cur.held);
        end
    end

    initial begin
        int         t;
        logic [5:0] b1_low;

        b1_low         = 6'h3F;
        b1_low[BTN_B1] = 1'b0;

        reset = 1'b1;
        applyStimulus(6'h00, 6'h00, 1'b0);
        wait_cycles(3);
        checkOutput("reset_hold", 6'h3F, 6'h3F, 1'b1, 1'b0);

        // Release reset with every line held pressed
        reset = 1'b0;
        t = cyc;
        push_exp(t + 5,  "t1_before",   6'h3F, 6'h3F, 1'b1, 1'b0);
        push_exp(t + 6,  "t1_pads",     6'h00, 6'h00, 1'b1, 1'b1);
        push_exp(t + 7,  "t1_nmi_fall", 6'h00, 6'h00, 1'b0, 1'b1);
        push_exp(t + 14, "t1_nmi_last", 6'h00, 6'h00, 1'b0, 1'b1);
        push_exp(t + 15, "t1_nmi_rise", 6'h00, 6'h00, 1'b1, 1'b1);
        wait_cycles(16);
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        push_exp(t + 5, "t1_rel_before", 6'h00, 6'h00, 1'b1, 1'b1);
        push_exp(t + 6, "t1_rel",        6'h3F, 6'h3F, 1'b1, 1'b0);
        push_exp(t + 9, "t1_idle",       6'h3F, 6'h3F, 1'b1, 1'b0);
        wait_cycles(10);

        // Short B1 glitch is rejected
        t = cyc;
        applyStimulus(b1_low, 6'h3F, 1'b1);
        for (int k = 1; k <= 10; k++) push_exp(t + k, "t2_glitch", 6'h3F, 6'h3F, 1'b1, 1'b0);
        wait_cycles(3);
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        wait_cycles(8);

        // B1 held six cycles is accepted, then recovers six edges after release
        t = cyc;
        applyStimulus(b1_low, 6'h3F, 1'b1);
        for (int k = 1; k <= 14; k++)
            push_exp(t + k, "t2_long", (k >= 6 && k <= 11) ? b1_low : 6'h3F, 6'h3F, 1'b1, 1'b0);
        wait_cycles(6);
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        wait_cycles(10);

        // Both pads change on the same edge
        t = cyc;
        applyStimulus(6'h3E, 6'h1F, 1'b1);
        push_exp(t + 5, "t3_before", 6'h3F, 6'h3F, 1'b1, 1'b0);
        push_exp(t + 6, "t3_both",   6'h3E, 6'h1F, 1'b1, 1'b0);
        push_exp(t + 7, "t3_hold",   6'h3E, 6'h1F, 1'b1, 1'b0);
        wait_cycles(8);
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        push_exp(t + 6, "t3_restore", 6'h3F, 6'h3F, 1'b1, 1'b0);
        wait_cycles(8);

        // Long PAUSE hold gives exactly one pulse
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b0);
        push_press(t, 100, "t4_hold");
        wait_cycles(100);
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        push_release(t, 10, "t4_release");
        wait_cycles(10);

        // Debounced release inside the pulse neither shortens it nor retriggers
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b0);
        for (int k = 1; k <= 30; k++)
            push_exp(t + k, "t5_rel_in_pulse", 6'h3F, 6'h3F,
                     !(k >= 7 && k <= 14), (k >= 6 && k <= 11));
        wait_cycles(6);
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        wait_cycles(24);

        // New press gives a second pulse; a bounce during it changes nothing
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b0);
        push_press(t, 20, "t5_second");
        wait_cycles(8);
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        wait_cycles(2);
        applyStimulus(6'h3F, 6'h3F, 1'b0);
        wait_cycles(12);
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        push_release(t, 10, "t5_release");
        wait_cycles(10);

        // Reset on the third pulse cycle
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b0);
        push_press(t, 9, "t6_pre_reset");
        wait_cycles(9);
        #1 reset = 1'b1;
        #1 checkOutput("t6_reset_async", 6'h3F, 6'h3F, 1'b1, 1'b0);
        wait_cycles(2);
        reset = 1'b0;
        t = cyc;
        push_press(t, 20, "t6_after_reset");
        wait_cycles(20);
        t = cyc;
        applyStimulus(6'h3F, 6'h3F, 1'b1);
        push_release(t, 8, "t6_release");
        wait_cycles(10);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
